// File: rtl/led_display_bcm_driver_pkg.sv
// led_display_bcm_driver_pkg: shared FSM encoding, BCM pixel layout and bit-plane extraction
package led_display_bcm_driver_pkg;

    localparam int MAX_DEPTH = 8;

    typedef enum logic [2:0] {
        BCM_IDLE,
        BCM_SHIFT,
        BCM_LATCH,
        BCM_BLANK,
        BCM_DISPLAY
    } bcm_state_t;

    typedef struct packed {
        logic [MAX_DEPTH-1:0] r_top;
        logic [MAX_DEPTH-1:0] g_top;
        logic [MAX_DEPTH-1:0] b_top;
        logic [MAX_DEPTH-1:0] r_bot;
        logic [MAX_DEPTH-1:0] g_bot;
        logic [MAX_DEPTH-1:0] b_bot;
    } rgb_bcm_pixel_t;

    // One bit plane of a pixel, ordered {r_top, g_top, b_top, r_bot, g_bot, b_bot}
    function automatic logic [5:0] plane_bits(input rgb_bcm_pixel_t px, input logic [2:0] p);
        return {px.r_top[p], px.g_top[p], px.b_top[p], px.r_bot[p], px.g_bot[p], px.b_bot[p]};
    endfunction

endpackage

// File: rtl/led_display_bcm_driver_if.sv
// led_display_bcm_driver_if: valid/ready row handshake between the row source and the BCM driver
interface led_display_bcm_driver_if #(
    parameter int NUM_COLS     = 64,
    parameter int NUM_ROWS     = 32,
    parameter int COLOUR_DEPTH = 4
);

    logic [NUM_COLS*6*COLOUR_DEPTH-1:0] row_in;
    logic [$clog2(NUM_ROWS/2)-1:0]      row_address_in;
    logic                               row_valid_in;
    logic                               row_ready_out;

    modport master (output row_in, row_address_in, row_valid_in, input row_ready_out);
    modport slave  (input row_in, row_address_in, row_valid_in, output row_ready_out);

endinterface

// File: rtl/led_display_bcm_driver_shift_engine.sv
// led_display_shift_engine: bit_clk and column sequencing for one bit plane, start/done handshake
module led_display_shift_engine #(
    parameter int NUM_COLS = 64,
    parameter int BCLK_DIV = 2,
    localparam int CW = NUM_COLS > 1 ? $clog2(NUM_COLS) : 1
) (
    input  logic          clk_in,
    input  logic          reset_in,
    input  logic          i_start,
    output logic          o_bit_clk,
    output logic          o_done,
    output logic          o_load,
    output logic [CW-1:0] o_load_col
);

    localparam int DW = $clog2(2*BCLK_DIV);
    localparam logic [DW-1:0] HI   = DW'(BCLK_DIV);
    localparam logic [DW-1:0] LAST = DW'(2*BCLK_DIV-1);
    localparam logic [CW-1:0] FIRST = CW'(NUM_COLS-1);

    logic          r_active;
    logic [DW-1:0] r_div;
    logic [CW-1:0] r_col;
    logic          r_bit_clk;
    logic          w_wrap;
    logic [DW-1:0] w_div_next;

    assign w_wrap     = r_active && r_div == LAST;
    assign w_div_next = w_wrap ? '0 : r_div + 1'b1;
    assign o_done     = w_wrap && r_col == '0;
    assign o_load     = i_start || (w_wrap && r_col != '0);
    assign o_load_col = i_start ? FIRST : r_col - 1'b1;
    assign o_bit_clk  = r_bit_clk;

    // Walk columns from the highest down; bit_clk is low for the first half of each column slot
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_active  <= 1'b0;
            r_div     <= '0;
            r_col     <= '0;
            r_bit_clk <= 1'b0;
        end else if (i_start) begin
            r_active  <= 1'b1;
            r_div     <= '0;
            r_col     <= FIRST;
            r_bit_clk <= 1'b0;
        end else if (r_active) begin
            r_div     <= w_div_next;
            r_bit_clk <= w_div_next >= HI;
            if (w_wrap && r_col == '0) r_active <= 1'b0;
            if (w_wrap && r_col != '0) r_col <= r_col - 1'b1;
        end
    end

endmodule

// File: rtl/led_display_bcm_driver.sv
// led_display_bcm_driver: HUB75 row driver with binary code modulation; LED_DISPLAY_BLANK_EN adds post-latch blanking
module led_display_bcm_driver
    import led_display_bcm_driver_pkg::*;
#(
    parameter int NUM_COLS      = 64,
    parameter int NUM_ROWS      = 32,
    parameter int COLOUR_DEPTH  = 4,
    parameter int BCLK_DIV      = 2,
    parameter int LSB_OE_CYCLES = 8,
    parameter int BLANK_CYCLES  = 4
) (
    input  logic                          clk_in,
    input  logic                          reset_in,
    led_display_bcm_driver_if.slave       row_if,
    output logic                          red_top_out,
    output logic                          green_top_out,
    output logic                          blue_top_out,
    output logic                          red_bot_out,
    output logic                          green_bot_out,
    output logic                          blue_bot_out,
    output logic                          bit_clk_out,
    output logic                          latch_out,
    output logic                          oe_n_out,
    output logic [$clog2(NUM_ROWS/2)-1:0] addr_out,
    output logic                          busy_out
);

    localparam int AW  = $clog2(NUM_ROWS/2);
    localparam int CW  = NUM_COLS > 1 ? $clog2(NUM_COLS) : 1;
    localparam int PW  = COLOUR_DEPTH > 1 ? $clog2(COLOUR_DEPTH) : 1;
    localparam int SW  = 6*COLOUR_DEPTH;
    localparam int RW  = NUM_COLS*SW;
    localparam int DCW = $clog2(LSB_OE_CYCLES) + COLOUR_DEPTH;
    localparam logic [2:0] S_IDLE    = BCM_IDLE;
    localparam logic [2:0] S_SHIFT   = BCM_SHIFT;
    localparam logic [2:0] S_LATCH   = BCM_LATCH;
    localparam logic [2:0] S_BLANK   = BCM_BLANK;
    localparam logic [2:0] S_DISPLAY = BCM_DISPLAY;

    logic [2:0]     r_state;
    logic [RW-1:0]  r_row;
    logic [AW-1:0]  r_addr;
    logic [PW-1:0]  r_plane;
    logic [DCW-1:0] r_disp;
    logic           r_ready;
    logic           r_busy;
    logic           r_latch;
    logic           r_oe_n;
    logic [AW-1:0]  r_addr_out;
    logic [5:0]     r_data;

    logic           w_hs;
    logic           w_start;
    logic           w_load;
    logic [CW-1:0]  w_load_col;
    logic           w_shift_done;
    logic           w_bit_clk;
    logic           w_disp_done;
    logic           w_last_plane;
    logic           w_blank_done;
    logic           w_enter_disp;
    logic [DCW-1:0] w_disp_len;
    logic [RW-1:0]  w_src_row;
    logic [SW-1:0]  w_slice;
    logic [2:0]     w_next_plane;
    rgb_bcm_pixel_t w_pix;

`ifdef LED_DISPLAY_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
    localparam int BW = $clog2(BLANK_CYCLES+1);
    logic [BW-1:0] r_blank;
    // Blanking countdown armed during LATCH, runs while in BLANK
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) r_blank <= '0;
        else if (r_state == S_LATCH) r_blank <= BW'(BLANK_CYCLES-1);
        else if (r_state == S_BLANK) r_blank <= r_blank - 1'b1;
    end
    assign w_blank_done = r_blank == '0;
`else
    localparam bit BLANK_EN = 1'b0;
    assign w_blank_done = 1'b1;
`endif

    assign w_hs         = r_state == S_IDLE && r_ready && row_if.row_valid_in;
    assign w_disp_done  = r_state == S_DISPLAY && r_disp == '0;
    assign w_last_plane = r_plane == PW'(COLOUR_DEPTH-1);
    assign w_start      = w_hs || (w_disp_done && !w_last_plane);
    assign w_enter_disp = (r_state == S_LATCH && !BLANK_EN) || (r_state == S_BLANK && w_blank_done);
    assign w_disp_len   = DCW'(LSB_OE_CYCLES) << r_plane;

    // The first column of a plane is fetched on the starting edge, straight from the bus when accepting
    assign w_src_row    = r_state == S_IDLE ? row_if.row_in : r_row;
    assign w_next_plane = r_state == S_IDLE ? 3'd0 : r_state == S_DISPLAY ? 3'(r_plane) + 3'd1 : 3'(r_plane);
    assign w_slice      = w_src_row[int'(w_load_col)*SW +: SW];
    assign w_pix.r_top  = MAX_DEPTH'(w_slice[6*COLOUR_DEPTH-1 -: COLOUR_DEPTH]);
    assign w_pix.g_top  = MAX_DEPTH'(w_slice[5*COLOUR_DEPTH-1 -: COLOUR_DEPTH]);
    assign w_pix.b_top  = MAX_DEPTH'(w_slice[4*COLOUR_DEPTH-1 -: COLOUR_DEPTH]);
    assign w_pix.r_bot  = MAX_DEPTH'(w_slice[3*COLOUR_DEPTH-1 -: COLOUR_DEPTH]);
    assign w_pix.g_bot  = MAX_DEPTH'(w_slice[2*COLOUR_DEPTH-1 -: COLOUR_DEPTH]);
    assign w_pix.b_bot  = MAX_DEPTH'(w_slice[COLOUR_DEPTH-1:0]);

    led_display_shift_engine #(
        .NUM_COLS (NUM_COLS),
        .BCLK_DIV (BCLK_DIV)
    ) u_shift (
        .clk_in     (clk_in),
        .reset_in   (reset_in),
        .i_start    (w_start),
        .o_bit_clk  (w_bit_clk),
        .o_done     (w_shift_done),
        .o_load     (w_load),
        .o_load_col (w_load_col)
    );

    // Main sequencer: accept row, then SHIFT/LATCH/[BLANK]/DISPLAY for each plane
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state    <= S_IDLE;
            r_row      <= '0;
            r_addr     <= '0;
            r_plane    <= '0;
            r_disp     <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_latch    <= 1'b0;
            r_oe_n     <= 1'b1;
            r_addr_out <= '0;
        end else begin
            r_latch <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ready <= !w_hs;
                    if (w_hs) begin
                        r_row   <= row_if.row_in;
                        r_addr  <= row_if.row_address_in;
                        r_plane <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_shift_done) begin
                        r_state    <= S_LATCH;
                        r_latch    <= 1'b1;
                        r_addr_out <= r_addr;
                    end
                end
                S_LATCH, S_BLANK: begin
                    r_state <= w_enter_disp ? S_DISPLAY : S_BLANK;
                    if (w_enter_disp) begin
                        r_oe_n <= 1'b0;
                        r_disp <= w_disp_len - 1'b1;
                    end
                end
                S_DISPLAY: begin
                    if (!w_disp_done) r_disp <= r_disp - 1'b1;
                    else begin
                        r_oe_n  <= 1'b1;
                        r_state <= w_last_plane ? S_IDLE : S_SHIFT;
                        r_ready <= w_last_plane;
                        r_busy  <= !w_last_plane;
                        if (!w_last_plane) r_plane <= r_plane + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Serial pixel bits change only when the shift engine moves to a new column
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) r_data <= '0;
        else if (w_load) r_data <= plane_bits(w_pix, w_next_plane);
    end

    assign row_if.row_ready_out = r_ready;
    assign {red_top_out, green_top_out, blue_top_out, red_bot_out, green_bot_out, blue_bot_out} = r_data;
    assign bit_clk_out = w_bit_clk;
    assign latch_out   = r_latch;
    assign oe_n_out    = r_oe_n;
    assign addr_out    = r_addr_out;
    assign busy_out    = r_busy;

endmodule

// File: tb/tb_led_display_bcm_driver.sv
// tb_led_display_bcm_driver: randomized rows checked against a plane/column level model of the panel waveform
module tb_led_display_bcm_driver;

    localparam int N   = 4;
    localparam int R   = 8;
    localparam int D   = 2;
    localparam int B   = 1;
    localparam int LSB = 4;
    localparam int BLK = 4;
    localparam int AW  = $clog2(R/2);
    localparam int RW  = N*6*D;
`ifdef LED_DISPLAY_BLANK_EN
    localparam int GAP = BLK;
`else
    localparam int GAP = 0;
`endif
    localparam int FRAME = D*(N*2*B+1) + LSB*((1<<D)-1) + D*GAP;
    localparam int T_D1  = 2*(2*N*B+1+GAP) + LSB + 1;

    logic clk_in = 1'b0;
    logic reset_in = 1'b1;
    logic red_top_out, green_top_out, blue_top_out, red_bot_out, green_bot_out, blue_bot_out;
    logic bit_clk_out, latch_out, oe_n_out, busy_out;
    logic [AW-1:0] addr_out;

    led_display_bcm_driver_if #(.NUM_COLS(N), .NUM_ROWS(R), .COLOUR_DEPTH(D)) row_if ();

    led_display_bcm_driver #(
        .NUM_COLS(N), .NUM_ROWS(R), .COLOUR_DEPTH(D),
        .BCLK_DIV(B), .LSB_OE_CYCLES(LSB), .BLANK_CYCLES(BLK)
    ) dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .row_if        (row_if),
        .red_top_out   (red_top_out),
        .green_top_out (green_top_out),
        .blue_top_out  (blue_top_out),
        .red_bot_out   (red_bot_out),
        .green_bot_out (green_bot_out),
        .blue_bot_out  (blue_bot_out),
        .bit_clk_out   (bit_clk_out),
        .latch_out     (latch_out),
        .oe_n_out      (oe_n_out),
        .addr_out      (addr_out),
        .busy_out      (busy_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    logic [5:0]    q_rise[$];
    logic [AW-1:0] q_addr[$];
    int            q_oe[$];
    int            q_gap[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] model_bits(input logic [RW-1:0] row, input int p, input int c);
        logic [5:0] v;
        v = '0;
        for (int ch = 0; ch < 6; ch++) v[5-ch] = row[c*6*D + (5-ch)*D + p];
        return v;
    endfunction

    function automatic logic [RW-1:0] rand_row();
        return RW'({$urandom(), $urandom()});
    endfunction

    task automatic wait_ready();
        for (int w = 0; w < 100 && !row_if.row_ready_out; w++) @(negedge clk_in);
        check("ready_before_row", row_if.row_ready_out, 1);
    endtask

    task automatic run_row(input logic [RW-1:0] row, input logic [AW-1:0] addr, input bit hold);
        int t, oe_run, gap, n_latch, latch_long, overlap, unstable, busy_cnt;
        logic pb, pl;
        logic [5:0] d, pd;
        q_rise.delete(); q_addr.delete(); q_oe.delete(); q_gap.delete();
        wait_ready();
        row_if.row_in = row;
        row_if.row_address_in = addr;
        row_if.row_valid_in = 1'b1;
        @(negedge clk_in);
        t = 1; oe_run = 0; gap = -1; n_latch = 0; latch_long = 0;
        overlap = 0; unstable = 0; busy_cnt = 0; pb = 1'b0; pl = 1'b0; pd = '0;
        while (!row_if.row_ready_out && t <= FRAME + 20) begin
            d = {red_top_out, green_top_out, blue_top_out, red_bot_out, green_bot_out, blue_bot_out};
            if (bit_clk_out && !pb) begin
                q_rise.push_back(d);
                if (d !== pd) unstable++;
            end
            if (latch_out) begin
                n_latch++;
                if (pl) latch_long++;
                q_addr.push_back(addr_out);
                gap = 0;
            end else if (gap >= 0) begin
                if (!oe_n_out) begin
                    q_gap.push_back(gap);
                    gap = -1;
                end else gap++;
            end
            if (!oe_n_out) oe_run++;
            else if (oe_run > 0) begin
                q_oe.push_back(oe_run);
                oe_run = 0;
            end
            if (!oe_n_out && (bit_clk_out || latch_out)) overlap++;
            if (busy_out) busy_cnt++;
            pb = bit_clk_out; pl = latch_out; pd = d;
            if (hold) row_if.row_in = rand_row();
            else row_if.row_valid_in = 1'b0;
            @(negedge clk_in);
            t++;
        end
        row_if.row_valid_in = 1'b0;
        if (oe_run > 0) q_oe.push_back(oe_run);
        check("ready_latency", t, FRAME + 1);
        check("rise_count", q_rise.size(), N*D);
        for (int i = 0; i < q_rise.size() && i < N*D; i++)
            check("serial_bits", q_rise[i], model_bits(row, i / N, N - 1 - (i % N)));
        check("latch_count", n_latch, D);
        check("latch_width", latch_long, 0);
        for (int i = 0; i < q_addr.size(); i++) check("latch_addr", q_addr[i], addr);
        check("oe_run_count", q_oe.size(), D);
        for (int i = 0; i < q_oe.size(); i++) check("oe_run_len", q_oe[i], LSB << i);
        check("blank_count", q_gap.size(), D);
        for (int i = 0; i < q_gap.size(); i++) check("blank_len", q_gap[i], GAP);
        check("oe_during_shift", overlap, 0);
        check("data_stable", unstable, 0);
        check("busy_cycles", busy_cnt, FRAME);
        check("end_oe_n", oe_n_out, 1);
        check("end_busy", busy_out, 0);
        @(negedge clk_in);
        check("single_accept", busy_out, 0);
    endtask

    initial begin
        logic [RW-1:0] row;
        logic [7:0] exp_red;
        row_if.row_in = '0;
        row_if.row_address_in = '0;
        row_if.row_valid_in = 1'b0;
        #12;
        check("rst_oe_n", oe_n_out, 1);
        check("rst_latch", latch_out, 0);
        check("rst_ready", row_if.row_ready_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_bit_clk", bit_clk_out, 0);
        check("rst_addr", addr_out, 0);
        check("rst_data", {red_top_out, green_top_out, blue_top_out, red_bot_out, green_bot_out, blue_bot_out}, 0);
        @(negedge clk_in);
        @(negedge clk_in);
        reset_in = 1'b0;
        check("ready_at_release", row_if.row_ready_out, 0);
        @(negedge clk_in);
        check("ready_after_release", row_if.row_ready_out, 1);

        row = '0;
        row[3*6*D + 5*D +: D] = 2'b01;
        row[2*6*D + 5*D +: D] = 2'b10;
        row[1*6*D + 5*D +: D] = 2'b11;
        row[0*6*D + 5*D +: D] = 2'b00;
        run_row(row, 2'd3, 1'b0);
        exp_red = 8'b1010_0110;
        for (int i = 0; i < 8 && i < q_rise.size(); i++) check("red_top_serial", q_rise[i][5], exp_red[7-i]);

        for (int k = 0; k < 3; k++) run_row(rand_row(), AW'($urandom_range(0, R/2-1)), 1'b0);
        run_row('0, 2'd0, 1'b0);
        run_row('1, 2'd1, 1'b0);
        for (int k = 0; k < 2; k++) run_row(rand_row(), AW'($urandom_range(0, R/2-1)), 1'b1);

        wait_ready();
        row_if.row_in = rand_row();
        row_if.row_address_in = 2'd2;
        row_if.row_valid_in = 1'b1;
        @(negedge clk_in);
        row_if.row_valid_in = 1'b0;
        repeat (T_D1 + 1) @(negedge clk_in);
        check("pre_reset_oe_n", oe_n_out, 0);
        reset_in = 1'b1;
        #1;
        check("async_rst_oe_n", oe_n_out, 1);
        check("async_rst_latch", latch_out, 0);
        check("async_rst_ready", row_if.row_ready_out, 0);
        check("async_rst_busy", busy_out, 0);
        check("async_rst_addr", addr_out, 0);
        @(negedge clk_in);
        reset_in = 1'b0;
        check("ready_at_rerelease", row_if.row_ready_out, 0);
        @(negedge clk_in);
        check("ready_after_rerelease", row_if.row_ready_out, 1);
        check("idle_after_reset_oe_n", oe_n_out, 1);
        run_row(rand_row(), AW'($urandom_range(0, R/2-1)), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
